// File: rtl/glevel_logic_gates.sv
// Bit-wise two-input gate library (AND, OR, NOT, XOR, NAND, NOR, XNOR) built
// from gate primitives, with a combinational result bus and an enabled register copy.
module glevel_logic_gates #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               en,
  output logic [7*WIDTH-1:0] y,
  output logic [7*WIDTH-1:0] y_q
);

  wire [7*WIDTH-1:0] gate_w;

  // One primitive per bit per field; field k sits at [k*WIDTH +: WIDTH].
  // X/Z propagation follows the primitive truth tables, nothing is masked.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and  u_and  (gate_w[0*WIDTH+i], a[i], b[i]);
    or   u_or   (gate_w[1*WIDTH+i], a[i], b[i]);
    not  u_not  (gate_w[2*WIDTH+i], a[i]);
    xor  u_xor  (gate_w[3*WIDTH+i], a[i], b[i]);
    nand u_nand (gate_w[4*WIDTH+i], a[i], b[i]);
    nor  u_nor  (gate_w[5*WIDTH+i], a[i], b[i]);
    xnor u_xnor (gate_w[6*WIDTH+i], a[i], b[i]);
  end

  assign y = gate_w;

  logic [7*WIDTH-1:0] cap_d;
  logic [7*WIDTH-1:0] cap_q;

  always_comb begin
    cap_d = cap_q;
    if (en) cap_d = gate_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cap_q <= '0;
    else        cap_q <= cap_d;
  end

  assign y_q = cap_q;

endmodule

// File: tb/tb_glevel_logic_gates.sv
// Bench for glevel_logic_gates: WIDTH=1 and WIDTH=4 instances against a
// truth-table reference model of the seven gate functions.
module tb_glevel_logic_gates;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        a1 = 1'b0, b1 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [6:0]  y1, y_q1;
  logic [27:0] y4, y_q4;

  int total = 0;
  int bad = 0;

  logic [6:0]  exp_q1;
  logic [27:0] exp_q4;

  glevel_logic_gates #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .en(en), .y(y1), .y_q(y_q1)
  );

  glevel_logic_gates #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .en(en), .y(y4), .y_q(y_q4)
  );

  always #5 clk = ~clk;

  // Truth tables indexed by {a,b}: bit 0 = (0,0), bit 3 = (1,1).
  function automatic logic [27:0] ref_vec(input int w, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] tt [7];
    logic [27:0] r;
    tt[0] = 4'b1000; // and
    tt[1] = 4'b1110; // or
    tt[2] = 4'b0011; // not a
    tt[3] = 4'b0110; // xor
    tt[4] = 4'b0111; // nand
    tt[5] = 4'b0001; // nor
    tt[6] = 4'b1001; // xnor
    r = '0;
    for (int k = 0; k < 7; k++)
      for (int i = 0; i < w; i++)
        r[k*w+i] = tt[k][{a[i], b[i]}];
    return r;
  endfunction

  function automatic logic [6:0] ref1(input logic a, input logic b);
    logic [27:0] t;
    t = ref_vec(1, {3'b000, a}, {3'b000, b});
    return t[6:0];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (y_q1 !== 7'd0) begin
      bad++; $display("FAIL reset_yq1 got=%b want=%b", y_q1, 7'd0);
    end
    total++;
    if (y_q4 !== 28'd0) begin
      bad++; $display("FAIL reset_yq4 got=%h want=%h", y_q4, 28'd0);
    end
  endtask

  task automatic test_truth_table_w1();
    logic [6:0] plan [4];
    plan[0] = 7'b1110100;
    plan[1] = 7'b0011110;
    plan[2] = 7'b0011010;
    plan[3] = 7'b1000011;
    for (int v = 0; v < 4; v++) begin
      a1 = v[1]; b1 = v[0];
      #1;
      total++;
      if (y1 !== plan[v]) begin
        bad++; $display("FAIL tt_w1 a=%b b=%b got=%b want=%b", a1, b1, y1, plan[v]);
      end
      total++;
      if (y1 !== ref1(a1, b1)) begin
        bad++; $display("FAIL tt_w1_model a=%b b=%b got=%b want=%b", a1, b1, y1, ref1(a1, b1));
      end
    end
  endtask

  task automatic test_vector_w4();
    logic [27:0] want;
    a4 = 4'b1100; b4 = 4'b1010;
    want = {4'b1001, 4'b0001, 4'b0111, 4'b0110, 4'b0011, 4'b1110, 4'b1000};
    #1;
    total++;
    if (y4 !== want) begin
      bad++; $display("FAIL vec_w4 got=%h want=%h", y4, want);
    end
  endtask

  task automatic test_random_comb();
    for (int n = 0; n < 40; n++) begin
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (y4 !== ref_vec(4, a4, b4)) begin
        bad++; $display("FAIL rand_w4 a=%b b=%b got=%h want=%h", a4, b4, y4, ref_vec(4, a4, b4));
      end
      total++;
      if (y1 !== ref1(a1, b1)) begin
        bad++; $display("FAIL rand_w1 a=%b b=%b got=%b want=%b", a1, b1, y1, ref1(a1, b1));
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; a1 = 1'b1; b1 = 1'b1;
    a4 = 4'b0110; b4 = 4'b0011;
    @(posedge clk); #1;
    total++;
    if (y_q1 !== 7'b1000011) begin
      bad++; $display("FAIL reg_capture got=%b want=%b", y_q1, 7'b1000011);
    end
    total++;
    if (y_q4 !== ref_vec(4, 4'b0110, 4'b0011)) begin
      bad++; $display("FAIL reg_capture_w4 got=%h want=%h", y_q4, ref_vec(4, 4'b0110, 4'b0011));
    end
    @(negedge clk);
    en = 1'b0; a1 = 1'b0; b1 = 1'b0; a4 = 4'b1111; b4 = 4'b0000;
    @(posedge clk); #1;
    total++;
    if (y_q1 !== 7'b1000011) begin
      bad++; $display("FAIL reg_hold got=%b want=%b", y_q1, 7'b1000011);
    end
    total++;
    if (y1 !== 7'b1110100) begin
      bad++; $display("FAIL reg_hold_y got=%b want=%b", y1, 7'b1110100);
    end
    total++;
    if (y_q4 !== ref_vec(4, 4'b0110, 4'b0011)) begin
      bad++; $display("FAIL reg_hold_w4 got=%h want=%h", y_q4, ref_vec(4, 4'b0110, 4'b0011));
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (y_q1 !== 7'd0) begin
      bad++; $display("FAIL reg_async_clear got=%b want=%b", y_q1, 7'd0);
    end
    total++;
    if (y1 !== 7'b1110100) begin
      bad++; $display("FAIL y_during_reset got=%b want=%b", y1, 7'b1110100);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    en = 1'b1; a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if (y_q1 !== 7'd0) begin
      bad++; $display("FAIL reset_held got=%b want=%b", y_q1, 7'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    total++;
    if (y_q1 !== 7'd0) begin
      bad++; $display("FAIL release_no_en got=%b want=%b", y_q1, 7'd0);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    total++;
    if (y_q1 !== 7'b0011110) begin
      bad++; $display("FAIL first_capture got=%b want=%b", y_q1, 7'b0011110);
    end
  endtask

  task automatic test_back_to_back();
    exp_q1 = ref1(1'b0, 1'b1);
    exp_q4 = y_q4;
    // Establish a known w4 register value first.
    @(negedge clk);
    en = 1'b1; a4 = 4'b1001; b4 = 4'b0101;
    @(posedge clk); #1;
    exp_q4 = ref_vec(4, 4'b1001, 4'b0101);
    exp_q1 = ref1(a1, b1);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      if (en) begin
        exp_q1 = ref1(a1, b1);
        exp_q4 = ref_vec(4, a4, b4);
      end
      @(posedge clk); #1;
      total++;
      if (y_q1 !== exp_q1) begin
        bad++; $display("FAIL b2b_w1 n=%0d en=%b got=%b want=%b", n, en, y_q1, exp_q1);
      end
      total++;
      if (y_q4 !== exp_q4) begin
        bad++; $display("FAIL b2b_w4 n=%0d en=%b got=%h want=%h", n, en, y_q4, exp_q4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table_w1();
    test_vector_w4();
    test_random_comb();
    test_registered();
    test_reset_midstream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glevel_logic_gates.md
Name: glevel_logic_gates

Overview:
Gate-level reference block that evaluates seven basic two-input logic functions (AND, OR, NOT, XOR, NAND, NOR, XNOR) bit-wise on two operand vectors. It drives a combinational result bus and a registered copy of that bus. It sits at the leaf level as a primitive-gate library / sanity block used by higher-level datapaths and bring-up benches.

Parameters:
WIDTH, 1, operand width in bits; every gate function is applied independently per bit.

Ports:
clk  input  1  clock; registered output stage updates on rising edge.
rst_n  input  1  asynchronous active-low reset; clears the registered output stage.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
en  input  1  capture enable for the registered stage.
y  output  7*WIDTH  combinational result bus, 7 fields of WIDTH bits.
y_q  output  7*WIDTH  registered copy of y.

Behaviour:
- Field k of y occupies bits [k*WIDTH +: WIDTH]; with WIDTH=1 field k is y[k].
- Field map, per bit i:
  - field 0 = a & b.
  - field 1 = a | b.
  - field 2 = ~a (single-input NOT of operand A; b is ignored).
  - field 3 = a ^ b.
  - field 4 = ~(a & b).
  - field 5 = ~(a | b).
  - field 6 = ~(a ^ b).
- y is purely combinational from a and b, zero cycles latency, with no dependence on clk, rst_n or en. It is valid within the same time step as an input change; a bench samples it after a #1 settle.
- Each field is built from gate primitives (and/or/not/xor/nand/nor/xnor), one instance per bit, replicated with generate over WIDTH. No behavioural operators on the y path.
- y_q: on async assertion of rst_n=0, y_q clears to all zeros immediately and holds zero while reset is low.
- y_q: on a rising clk with rst_n=1 and en=1, y_q takes the value of y. With en=0, y_q holds.
- Reset deasserted mid-stream: the first capture occurs on the first rising edge with rst_n=1 and en=1.
- y remains correct during reset.
- X or Z on an input bit propagates per gate-primitive semantics, for example 0 & x = 0 and 1 | x = 1. No X-masking.
- No state other than y_q. No handshake. No overflow or boundary conditions beyond reset.

Test Plan:
- WIDTH=1, a=0 b=0 -> after #1, y=7'b1110100: and0 or0 not1 xor0 nand1 nor1 xnor1.
- WIDTH=1, a=0 b=1 -> y=7'b0011110: and0 or1 not1 xor1 nand1 nor0 xnor0.
- WIDTH=1, a=1 b=0 -> y=7'b0011010: and0 or1 not0 xor1 nand1 nor0 xnor0.
- WIDTH=1, a=1 b=1 -> y=7'b1000011: and1 or1 not0 xor0 nand0 nor0 xnor1.
- WIDTH=4, a=4'b1100 b=4'b1010 -> fields 0..6 = 1000, 1110, 0011, 0110, 0111, 0001, 1001.
- Registered stage, WIDTH=1: rst_n=0 -> y_q=0 immediately without a clock edge. Release reset, en=1, a=1 b=1, clock edge -> y_q=7'b1000011. Then en=0, a=0 b=0, clock edge -> y_q holds 7'b1000011 while y=7'b1110100. Assert rst_n=0 between edges -> y_q=0 at once.
